tcm_loader: RTL
===============

# tcm_loader

Initiator-side loader for a TCM scratchpad SRAM port. It accepts a byte stream over a valid/ready handshake, parses a little-endian word-count header, and assembles little-endian data words. Each word is written to consecutive SRAM word addresses from a latched base address. It drives one port of the dual-port TCM SRAM (en/we/be/addr/data, plus the read data and ready returned by that port), which lets a UART or debug path preload boot code while the core uses the other port.

## Interface
- DATA_WIDTH, 32, SRAM word width in bits (multiple of 8); also the header width.
- N_ENTRIES, 1024, SRAM depth in words; AW = $clog2(N_ENTRIES).

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  begin a load session; ignored unless idle.
- base_addr_i  in  AW  first word address; latched on accepted start.
- s_valid_i  in  1  byte valid.
- s_data_i  in  8  stream byte.
- s_ready_o  out  1  byte accepted when s_valid_i & s_ready_o.
- mem_en_o  out  1  SRAM port enable.
- mem_we_o  out  1  SRAM write enable.
- mem_be_o  out  DATA_WIDTH/8  byte enables.
- mem_addr_o  out  AW  word address.
- mem_data_o  out  DATA_WIDTH  write data.
- mem_data_i  in  DATA_WIDTH  SRAM read data.
- mem_ready_i  in  1  SRAM read-data valid, one cycle after a read enable.
- busy_o  out  1  session in progress (any state other than IDLE).
- done_o  out  1  one-cycle pulse at session end.
- err_o  out  1  sticky error; cleared on the next accepted start.
- words_o  out  AW+1  words written in the current or last session.

## Operation
- States: IDLE, HDR, DATA, WRITE, VRD, VCHK, DONE. VRD and VCHK exist only with the macro defined.
- IDLE:
  - s_ready_o=0.
  - start_i=1 → HDR. Latch base into cur_addr, clear err_o, words_o and byte index.
- HDR:
  - s_ready_o=1.
  - Accepted byte k (k = 0..DATA_WIDTH/8-1) fills bits [8k+7:8k] of count.
  - After the last header byte, the next state is decided as follows:
    - count=0 → DONE.
    - count > N_ENTRIES − base, compared at DATA_WIDTH+1 bits → set err_o, go to DONE, no writes.
    - otherwise → DATA.
- DATA:
  - s_ready_o=1.
  - Byte k fills lane k of the word register.
  - After lane DATA_WIDTH/8-1 is filled → WRITE.
- WRITE:
  - s_ready_o=0.
  - mem_en_o=1, mem_we_o=1, mem_be_o=all ones, mem_addr_o=cur_addr, mem_data_o=word, for exactly one cycle.
  - Then cur_addr+1, words_o+1, remaining−1.
  - Next state: remaining reaches 0 → DONE, else DATA.
  - With the macro defined, WRITE goes to VRD instead.
- VRD:
  - mem_en_o=1, mem_we_o=0, same address, one cycle → VCHK.
- VCHK:
  - Wait for mem_ready_i, then compare mem_data_i to the word.
  - Mismatch sets err_o; the load continues.
  - Next state: remaining=0 → DONE, else DATA.
- DONE: done_o=1 for one cycle → IDLE.
- The range check guarantees addresses never wrap.
- Outside WRITE and VRD, mem_en_o, mem_we_o and mem_be_o are all 0.

## Timing
- Reset: every output is 0, state IDLE, all internal counters 0.
- start_i is sampled in IDLE; HDR begins the next cycle.
- Header: one byte per cycle at best; s_valid_i gaps stall without loss.
- A byte presented while s_ready_o=0 is held by the source and not consumed.
- Throughput without the macro: DATA_WIDTH/8+1 cycles per word (5 at 32 bits). With the macro: DATA_WIDTH/8+3 cycles per word.
- done_o asserts the cycle after the final WRITE (or VCHK, or the last header byte when count=0 or the range check fails).
- Read-after-write: the SRAM commits the write at the edge ending WRITE, so VRD reads back the new data.
- start_i while busy_o=1 is ignored.
- Reset mid-session: immediate return to IDLE; words already written stay in the SRAM; no done_o pulse.

## Configuration
- TCM_LOADER_VERIFY_EN defined: VRD/VCHK readback after each write; mismatch sets err_o.
- Undefined: VRD/VCHK are not built; WRITE → DATA or DONE directly; mem_data_i and mem_ready_i are unused; err_o reports only range errors.

## Test plan
- Basic load: base=0; bytes 02 00 00 00, 11 22 33 44 55 66 77 88 → writes addr0=0x44332211, addr1=0x88776655, one done_o pulse, words_o=2, err_o=0.
- Empty header: header 00 00 00 00 → done_o pulse one cycle after the last header byte, mem_en_o never asserted, words_o=0.
- Range: base=1020 with count=5 → err_o=1, done_o, no mem_en_o. Base=1020 with count=4 → last write to addr 1023, err_o=0.
- Backpressure/gaps: s_valid_i toggled every other cycle, and a byte held during WRITE → same SRAM contents as the basic load, no byte lost or duplicated.
- Reset mid-DATA, then a new start with base=8 and count=1, word 0xDEADBEEF → all outputs 0 after reset, then addr8=0xDEADBEEF, done_o pulse.
- With TCM_LOADER_VERIFY_EN: bench corrupts mem_data_i on the 2nd readback → err_o=1 from VCHK onward, all 3 words still written, done_o pulse, words_o=3.

Source files
------------

// File: rtl/tcm_loader_if.sv
// Byte-stream and TCM SRAM port bundle for tcm_loader.
// master = loader side, slave = stream source plus SRAM.
interface tcm_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 10
);
  logic                    s_valid_i;
  logic [7:0]              s_data_i;
  logic                    s_ready_o;
  logic                    mem_en_o;
  logic                    mem_we_o;
  logic [DATA_WIDTH/8-1:0] mem_be_o;
  logic [AW-1:0]           mem_addr_o;
  logic [DATA_WIDTH-1:0]   mem_data_o;
  logic [DATA_WIDTH-1:0]   mem_data_i;
  logic                    mem_ready_i;

  modport master (
    input  s_valid_i, s_data_i, mem_data_i, mem_ready_i,
    output s_ready_o, mem_en_o, mem_we_o, mem_be_o,
    output mem_addr_o, mem_data_o
  );

  modport slave (
    output s_valid_i, s_data_i, mem_data_i, mem_ready_i,
    input  s_ready_o, mem_en_o, mem_we_o, mem_be_o,
    input  mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/tcm_loader.sv
// Byte-stream to TCM SRAM loader with LE count header.
// TCM_LOADER_VERIFY_EN adds a readback check after every write.
module tcm_loader #(
  parameter  int DATA_WIDTH = 32,
  parameter  int N_ENTRIES  = 1024,
  localparam int AW         = $clog2(N_ENTRIES)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  tcm_loader_if.master  bus,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW:0]   words_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = DATA_WIDTH + 1;

`ifdef TCM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE, HDR, DATA, WRITE, VRD, VCHK, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, HDR, DATA, WRITE, DONE
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [AW:0]           words_q, words_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  last;
  logic [CW-1:0]         room;

  assign last = (idx_q == IW'(NB - 1));
  assign room = CW'(N_ENTRIES) - CW'(addr_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      words_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    words_d       = words_q;
    cnt_d         = cnt_q;
    word_d        = word_q;
    idx_d         = idx_q;
    err_d         = err_q;
    bus.s_ready_o = 1'b0;
    bus.mem_en_o  = 1'b0;
    bus.mem_we_o  = 1'b0;
    bus.mem_be_o  = '0;
    done_o        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = HDR;
          addr_d  = base_addr_i;
          err_d   = 1'b0;
          words_d = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      HDR: begin
        bus.s_ready_o = 1'b1;
        if (bus.s_valid_i) begin
          cnt_d[{idx_q, 3'b000} +: 8] = bus.s_data_i;
          idx_d = last ? '0 : idx_q + 1'b1;
          if (last) begin
            // room is computed one bit wider so huge counts cannot alias
            if (cnt_d == '0) begin
              state_d = DONE;
            end else if ({1'b0, cnt_d} > room) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        bus.s_ready_o = 1'b1;
        if (bus.s_valid_i) begin
          word_d[{idx_q, 3'b000} +: 8] = bus.s_data_i;
          idx_d = last ? '0 : idx_q + 1'b1;
          if (last) state_d = WRITE;
        end
      end
      WRITE: begin
        bus.mem_en_o = 1'b1;
        bus.mem_we_o = 1'b1;
        bus.mem_be_o = '1;
        words_d      = words_q + 1'b1;
        cnt_d        = cnt_q - 1'b1;
`ifdef TCM_LOADER_VERIFY_EN
        state_d      = VRD;
`else
        addr_d       = addr_q + 1'b1;
        state_d      = (cnt_q == DATA_WIDTH'(1)) ? DONE : DATA;
`endif
      end
`ifdef TCM_LOADER_VERIFY_EN
      VRD: begin
        bus.mem_en_o = 1'b1;
        addr_d       = addr_q + 1'b1;
        state_d      = VCHK;
      end
      VCHK: begin
        if (bus.mem_ready_i) begin
          if (bus.mem_data_i != word_q) err_d = 1'b1;
          state_d = (cnt_q == '0) ? DONE : DATA;
        end
      end
`endif
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef TCM_LOADER_VERIFY_EN
  logic unused_rd;
  assign unused_rd = ^{bus.mem_data_i, bus.mem_ready_i};
`endif

  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = word_q;
  assign busy_o         = (state_q != IDLE);
  assign err_o          = err_q;
  assign words_o        = words_q;

endmodule
